// File: rtl/udp_calc_engine.sv
// Inline AXI-Stream calculator: rewrites R in matching IPv4/UDP packets, passes others through.
// Optional multiply opcode enabled by defining CALC_MUL_EN.
module udp_calc_engine #(
   parameter int unsigned DATA_WIDTH = 512,
   parameter int unsigned OPERAND_W  = 32,
   parameter int unsigned TUSER_W    = 48
) (
   input  logic                    axis_aclk,
   input  logic                    aresetn,
   input  logic                    cfg_en,
   input  logic [15:0]             cfg_udp_port,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic [TUSER_W-1:0]      s_axis_tuser,
   input  logic                    s_axis_tlast,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic [TUSER_W-1:0]      m_axis_tuser,
   output logic                    m_axis_tlast,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [31:0]             stat_calc_cnt,
   output logic [31:0]             stat_byp_cnt,
   output logic [31:0]             stat_badop_cnt
);

   localparam int unsigned KeepW   = DATA_WIDTH / 8;
   localparam int unsigned OpBytes = OPERAND_W / 8;
   localparam int unsigned AOff    = 44;
   localparam int unsigned BOff    = 44 + OpBytes;
   localparam int unsigned ROff    = 44 + 2 * OpBytes;
   localparam int unsigned KeepIdx = 43 + 3 * OpBytes;

   localparam logic [15:0] OpAdd  = 16'h000D;
   localparam logic [15:0] OpSub  = 16'h001A;
   localparam logic [15:0] OpAnd  = 16'h0027;
   localparam logic [15:0] OpOr   = 16'h0034;
   localparam logic [15:0] OpXor  = 16'h0041;
   localparam logic [15:0] OpUmin = 16'h004E;
   localparam logic [15:0] OpUmax = 16'h005B;
`ifdef CALC_MUL_EN
   localparam logic [15:0] OpMul  = 16'h0068;
`endif

   if ((DATA_WIDTH % 64) != 0 || (OPERAND_W % 8) != 0 || (OPERAND_W == 0) ||
       (44 + 3 * OpBytes > KeepW)) begin : g_bad_cfg
      $error("udp_calc_engine: payload fields do not fit in one DATA_WIDTH beat");
   end

   // Stage 1: registered beat plus parse result of the SOP beat
   logic                  v1_q, sop_q, sop1_q, match1_q, last1_q;
   logic [DATA_WIDTH-1:0] data1_q;
   logic [KeepW-1:0]      keep1_q;
   logic [TUSER_W-1:0]    user1_q;

   // Stage 2: output registers and per-packet classification
   logic                  v2_q, last2_q, calc2_q, badop2_q, byp2_q;
   logic [DATA_WIDTH-1:0] data2_q;
   logic [KeepW-1:0]      keep2_q;
   logic [TUSER_W-1:0]    user2_q;
   logic [31:0]           calc_cnt_q, byp_cnt_q, badop_cnt_q;

   logic                  rdy2, s_acc, match_s;
   logic [15:0]           opcode;
   logic [OPERAND_W-1:0]  op_a, op_b, res;
   logic                  known, rewrite;
   logic [DATA_WIDTH-1:0] data_nx;

   assign rdy2          = !v2_q || m_axis_tready;
   assign s_axis_tready = !v1_q || rdy2;
   assign s_acc         = s_axis_tvalid && s_axis_tready;

   assign match_s = cfg_en
      && (s_axis_tdata[8*12 +: 8] == 8'h08) && (s_axis_tdata[8*13 +: 8] == 8'h00)
      && (s_axis_tdata[8*14 +: 8] == 8'h45) && (s_axis_tdata[8*23 +: 8] == 8'h11)
      && ({s_axis_tdata[8*36 +: 8], s_axis_tdata[8*37 +: 8]} == cfg_udp_port)
      && s_axis_tkeep[KeepIdx];

   always_ff @(posedge axis_aclk or negedge aresetn) begin
      if (!aresetn) begin
         v1_q     <= 1'b0;
         sop_q    <= 1'b1;
         sop1_q   <= 1'b0;
         match1_q <= 1'b0;
         last1_q  <= 1'b0;
         data1_q  <= '0;
         keep1_q  <= '0;
         user1_q  <= '0;
      end else begin
         if (s_acc) sop_q <= s_axis_tlast;
         if (s_axis_tready) begin
            v1_q <= s_axis_tvalid;
            if (s_axis_tvalid) begin
               sop1_q   <= sop_q;
               match1_q <= match_s;
               last1_q  <= s_axis_tlast;
               data1_q  <= s_axis_tdata;
               keep1_q  <= s_axis_tkeep;
               user1_q  <= s_axis_tuser;
            end
         end
      end
   end

   // Operands are big-endian on the wire
   always_comb begin
      opcode = {data1_q[8*42 +: 8], data1_q[8*43 +: 8]};
      op_a   = '0;
      op_b   = '0;
      for (int j = 0; j < OpBytes; j++) begin
         op_a[8*(OpBytes-1-j) +: 8] = data1_q[8*(AOff+j) +: 8];
         op_b[8*(OpBytes-1-j) +: 8] = data1_q[8*(BOff+j) +: 8];
      end
   end

   always_comb begin
      known = 1'b1;
      res   = '0;
      case (opcode)
         OpAdd:  res = op_a + op_b;
         OpSub:  res = op_a - op_b;
         OpAnd:  res = op_a & op_b;
         OpOr:   res = op_a | op_b;
         OpXor:  res = op_a ^ op_b;
         OpUmin: res = (op_a < op_b) ? op_a : op_b;
         OpUmax: res = (op_a > op_b) ? op_a : op_b;
`ifdef CALC_MUL_EN
         OpMul:  res = op_a * op_b;
`endif
         default: known = 1'b0;
      endcase
   end

   always_comb begin
      rewrite = sop1_q && match1_q && known;
      data_nx = data1_q;
      if (rewrite) begin
         for (int j = 0; j < OpBytes; j++) begin
            data_nx[8*(ROff+j) +: 8] = res[8*(OpBytes-1-j) +: 8];
         end
      end
   end

   always_ff @(posedge axis_aclk or negedge aresetn) begin
      if (!aresetn) begin
         v2_q     <= 1'b0;
         last2_q  <= 1'b0;
         calc2_q  <= 1'b0;
         badop2_q <= 1'b0;
         byp2_q   <= 1'b0;
         data2_q  <= '0;
         keep2_q  <= '0;
         user2_q  <= '0;
      end else if (rdy2) begin
         v2_q <= v1_q;
         if (v1_q) begin
            data2_q  <= data_nx;
            keep2_q  <= keep1_q;
            user2_q  <= user1_q;
            last2_q  <= last1_q;
            calc2_q  <= rewrite;
            badop2_q <= sop1_q && match1_q && !known;
            byp2_q   <= sop1_q && !match1_q;
         end
      end
   end

   // Stats advance only when the classified SOP beat actually leaves
   always_ff @(posedge axis_aclk or negedge aresetn) begin
      if (!aresetn) begin
         calc_cnt_q  <= '0;
         byp_cnt_q   <= '0;
         badop_cnt_q <= '0;
      end else if (v2_q && m_axis_tready) begin
         if (calc2_q)  calc_cnt_q  <= calc_cnt_q + 32'd1;
         if (byp2_q)   byp_cnt_q   <= byp_cnt_q + 32'd1;
         if (badop2_q) badop_cnt_q <= badop_cnt_q + 32'd1;
      end
   end

   assign m_axis_tdata   = data2_q;
   assign m_axis_tkeep   = keep2_q;
   assign m_axis_tuser   = user2_q;
   assign m_axis_tlast   = last2_q;
   assign m_axis_tvalid  = v2_q;
   assign stat_calc_cnt  = calc_cnt_q;
   assign stat_byp_cnt   = byp_cnt_q;
   assign stat_badop_cnt = badop_cnt_q;

endmodule

// File: tb/tb_udp_calc_engine.sv
// Directed bench for udp_calc_engine: vector table of single-beat packets plus
// multi-beat backpressure and mid-packet reset sequences.
module tb_udp_calc_engine;

   localparam int unsigned DW = 512;
   localparam int unsigned KW = DW / 8;
   localparam int unsigned UW = 48;
   localparam int unsigned NV = 15;

   logic          axis_aclk = 1'b0;
   logic          aresetn;
   logic          cfg_en;
   logic [15:0]   cfg_udp_port;
   logic [DW-1:0] s_axis_tdata;
   logic [KW-1:0] s_axis_tkeep;
   logic [UW-1:0] s_axis_tuser;
   logic          s_axis_tlast, s_axis_tvalid, s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic [UW-1:0] m_axis_tuser;
   logic          m_axis_tlast, m_axis_tvalid, m_axis_tready;
   logic [31:0]   stat_calc_cnt, stat_byp_cnt, stat_badop_cnt;

   udp_calc_engine dut (
      .axis_aclk      (axis_aclk),
      .aresetn        (aresetn),
      .cfg_en         (cfg_en),
      .cfg_udp_port   (cfg_udp_port),
      .s_axis_tdata   (s_axis_tdata),
      .s_axis_tkeep   (s_axis_tkeep),
      .s_axis_tuser   (s_axis_tuser),
      .s_axis_tlast   (s_axis_tlast),
      .s_axis_tvalid  (s_axis_tvalid),
      .s_axis_tready  (s_axis_tready),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tkeep   (m_axis_tkeep),
      .m_axis_tuser   (m_axis_tuser),
      .m_axis_tlast   (m_axis_tlast),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .stat_calc_cnt  (stat_calc_cnt),
      .stat_byp_cnt   (stat_byp_cnt),
      .stat_badop_cnt (stat_badop_cnt)
   );

   initial forever #5 axis_aclk = ~axis_aclk;

   // cls: 0 = rewritten, 1 = bypass, 2 = bad opcode
   typedef struct packed {
      logic [15:0] port;
      logic [15:0] etype;
      logic        en;
      logic        short_keep;
      logic [15:0] op;
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  cls;
      logic [31:0] r;
   } vec_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic [UW-1:0] user;
      logic          last;
   } beat_t;

   vec_t  vecs [NV];
   beat_t outq [$];
   int    n_tests = 0;
   int    n_fail  = 0;
   int    exp_calc = 0, exp_byp = 0, exp_bad = 0;
   logic  rand_rdy = 1'b0;
   logic  rdy_fix  = 1'b1;

   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge axis_aclk);
         #1;
         m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fix;
      end
   end

   initial forever begin
      @(negedge axis_aclk);
      if (m_axis_tvalid && m_axis_tready)
         outq.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast});
   end

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timed out");
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk(input logic [15:0] port, input logic [15:0] etype,
                                        input logic [15:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] r);
      logic [DW-1:0] d;
      for (int i = 0; i < KW; i++) d[8*i +: 8] = 8'(i * 7 + 3);
      d[8*12 +: 8] = etype[15:8];
      d[8*13 +: 8] = etype[7:0];
      d[8*14 +: 8] = 8'h45;
      d[8*23 +: 8] = 8'h11;
      d[8*36 +: 8] = port[15:8];
      d[8*37 +: 8] = port[7:0];
      d[8*42 +: 8] = op[15:8];
      d[8*43 +: 8] = op[7:0];
      for (int j = 0; j < 4; j++) begin
         d[8*(44+j) +: 8] = a[8*(3-j) +: 8];
         d[8*(48+j) +: 8] = b[8*(3-j) +: 8];
         d[8*(52+j) +: 8] = r[8*(3-j) +: 8];
      end
      return d;
   endfunction

   // Called at a negedge; returns at the negedge after the beat is accepted
   task automatic drive(input logic [DW-1:0] d, input logic [KW-1:0] k,
                        input logic [UW-1:0] u, input logic l);
      int budget = 0;
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tuser  = u;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      #1;
      while (!s_axis_tready && budget < 1000) begin
         @(negedge axis_aclk);
         #1;
         budget++;
      end
      chk32("ingress_ready", 32'(s_axis_tready), 32'd1);
      @(posedge axis_aclk);
      @(negedge axis_aclk);
      s_axis_tvalid = 1'b0;
   endtask

   task automatic wait_out(input int n, input string name);
      int budget = 0;
      while (outq.size() < n && budget < 2000) begin
         @(negedge axis_aclk);
         budget++;
      end
      chk32({name, "_beats"}, 32'(outq.size()), 32'(n));
      repeat (2) @(negedge axis_aclk);
   endtask

   function automatic beat_t pop();
      beat_t b = '0;
      if (outq.size() > 0) b = outq.pop_front();
      return b;
   endfunction

   task automatic chk_cnt(input string name);
      chk32({name, "_calc"}, stat_calc_cnt, 32'(exp_calc));
      chk32({name, "_byp"}, stat_byp_cnt, 32'(exp_byp));
      chk32({name, "_badop"}, stat_badop_cnt, 32'(exp_bad));
   endtask

   initial begin
      vec_t          v;
      beat_t         bt;
      logic [DW-1:0] d_in, d_exp, d2;
      logic [DW-1:0] din [4];
      logic [DW-1:0] dex [4];
      logic [KW-1:0] keep;
      logic [UW-1:0] user;

      vecs[0]  = '{16'h10E1, 16'h0800, 1'b1, 1'b0, 16'h001A, 32'd3, 32'd2, 2'd0, 32'd1};
      vecs[1]  = '{16'h10E1, 16'h0800, 1'b1, 1'b0, 16'h000D, 32'd3, 32'd2, 2'd0, 32'd5};
      vecs[2]  = '{16'h10E1, 16'h0800, 1'b1, 1'b0, 16'h000D, 32'hFFFFFFFF, 32'd2, 2'd0, 32'd1};
      vecs[3]  = '{16'h10E1, 16'h0800, 1'b1, 1'b0, 16'h004E, 32'd3, 32'd2, 2'd0, 32'd2};
      vecs[4]  = '{16'h10E1, 16'h0800, 1'b1, 1'b0, 16'h005B, 32'd3, 32'd2, 2'd0, 32'd3};
      vecs[5]  = '{16'h10E1, 16'h0800, 1'b1, 1'b0, 16'h0027, 32'hF0F0F0F0, 32'hFF00FF00,
                   2'd0, 32'hF000F000};
      vecs[6]  = '{16'h10E1, 16'h0800, 1'b1, 1'b0, 16'h0034, 32'hF0F0F0F0, 32'h0F0F0000,
                   2'd0, 32'hFFFFF0F0};
      vecs[7]  = '{16'h10E1, 16'h0800, 1'b1, 1'b0, 16'h0041, 32'hFFFF0000, 32'h0F0F0F0F,
                   2'd0, 32'hF0F00F0F};
      vecs[8]  = '{16'h10E1, 16'h0800, 1'b1, 1'b0, 16'h001A, 32'd2, 32'd3, 2'd0, 32'hFFFFFFFF};
      vecs[9]  = '{16'h1234, 16'h0800, 1'b1, 1'b0, 16'h000D, 32'd3, 32'd2, 2'd1, 32'd0};
      vecs[10] = '{16'h10E1, 16'h86DD, 1'b1, 1'b0, 16'h000D, 32'd3, 32'd2, 2'd1, 32'd0};
      vecs[11] = '{16'h10E1, 16'h0800, 1'b0, 1'b0, 16'h000D, 32'd3, 32'd2, 2'd1, 32'd0};
`ifdef CALC_MUL_EN
      vecs[12] = '{16'h10E1, 16'h0800, 1'b1, 1'b0, 16'h0068, 32'd7, 32'd6, 2'd0, 32'h2A};
`else
      vecs[12] = '{16'h10E1, 16'h0800, 1'b1, 1'b0, 16'h0068, 32'd7, 32'd6, 2'd2, 32'd0};
`endif
      vecs[13] = '{16'h10E1, 16'h0800, 1'b1, 1'b0, 16'h0099, 32'd7, 32'd6, 2'd2, 32'd0};
      vecs[14] = '{16'h10E1, 16'h0800, 1'b1, 1'b1, 16'h000D, 32'd3, 32'd2, 2'd1, 32'd0};

      aresetn       = 1'b0;
      cfg_en        = 1'b1;
      cfg_udp_port  = 16'h10E1;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tuser  = '0;
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b0;

      repeat (3) @(negedge axis_aclk);
      chk32("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk32("reset_tready", 32'(s_axis_tready), 32'd1);
      chk_cnt("reset");
      aresetn = 1'b1;
      @(negedge axis_aclk);

      for (int i = 0; i < NV; i++) begin
         v      = vecs[i];
         cfg_en = v.en;
         d_in   = mk(v.port, v.etype, v.op, v.a, v.b, 32'hDEADBEEF);
         d_exp  = (v.cls == 2'd0) ? mk(v.port, v.etype, v.op, v.a, v.b, v.r) : d_in;
         keep   = v.short_keep ? 64'h007F_FFFF_FFFF_FFFF : '1;
         user   = UW'(48'hC0DE_0000_0000 + 48'(i));
         outq.delete();
         drive(d_in, keep, user, 1'b1);
         if (i == 0) begin
            chk32("latency_s1", 32'(m_axis_tvalid), 32'd0);
            @(negedge axis_aclk);
            chk32("latency_s2", 32'(m_axis_tvalid), 32'd1);
         end
         wait_out(1, $sformatf("vec%0d", i));
         bt = pop();
         chk($sformatf("vec%0d_data", i), bt.data, d_exp);
         chk($sformatf("vec%0d_side", i), DW'({bt.keep, bt.user, bt.last}),
             DW'({keep, user, 1'b1}));
         case (v.cls)
            2'd0:    exp_calc++;
            2'd1:    exp_byp++;
            default: exp_bad++;
         endcase
         chk_cnt($sformatf("vec%0d", i));
      end
      cfg_en = 1'b1;

      // Three-beat packet then a single-beat packet under random egress backpressure
      rand_rdy = 1'b1;
      din[0] = mk(16'h10E1, 16'h0800, 16'h000D, 32'd10, 32'd20, 32'hDEADBEEF);
      dex[0] = mk(16'h10E1, 16'h0800, 16'h000D, 32'd10, 32'd20, 32'd30);
      din[1] = mk(16'h10E1, 16'h0800, 16'h000D, 32'd1, 32'd1, 32'hDEADBEEF);
      dex[1] = din[1];
      for (int w = 0; w < DW / 32; w++) d2[32*w +: 32] = $urandom;
      din[2] = d2;
      dex[2] = d2;
      din[3] = mk(16'h10E1, 16'h0800, 16'h0041, 32'h12345678, 32'h0F0F0F0F, 32'hDEADBEEF);
      dex[3] = mk(16'h10E1, 16'h0800, 16'h0041, 32'h12345678, 32'h0F0F0F0F, 32'h1D3B5977);
      outq.delete();
      for (int i = 0; i < 4; i++) drive(din[i], '1, UW'(48'hBEEF_0000_0000 + 48'(i)), i >= 2);
      wait_out(4, "multi");
      for (int i = 0; i < 4; i++) begin
         bt = pop();
         chk($sformatf("multi%0d_data", i), bt.data, dex[i]);
         chk($sformatf("multi%0d_side", i), DW'({bt.keep, bt.user, bt.last}),
             DW'({{KW{1'b1}}, UW'(48'hBEEF_0000_0000 + 48'(i)), i >= 2}));
      end
      exp_calc += 2;
      rand_rdy = 1'b0;
      rdy_fix  = 1'b1;
      repeat (2) @(negedge axis_aclk);
      chk_cnt("multi");

      // Reset with two non-last beats stuck in the pipeline
      rdy_fix = 1'b0;
      repeat (2) @(negedge axis_aclk);
      drive(din[0], '1, '0, 1'b0);
      drive(din[1], '1, '0, 1'b0);
      chk32("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
      aresetn = 1'b0;
      #1;
      exp_calc = 0;
      exp_byp  = 0;
      exp_bad  = 0;
      chk32("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk_cnt("midrst");
      @(negedge axis_aclk);
      aresetn = 1'b1;
      rdy_fix = 1'b1;
      repeat (2) @(negedge axis_aclk);
      outq.delete();
      drive(mk(16'h10E1, 16'h0800, 16'h005B, 32'd5, 32'd9, 32'hDEADBEEF), '1, '0, 1'b1);
      wait_out(1, "postrst");
      bt = pop();
      chk("postrst_data", bt.data, mk(16'h10E1, 16'h0800, 16'h005B, 32'd5, 32'd9, 32'd9));
      exp_calc = 1;
      chk_cnt("postrst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
